// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Drives the datapath selects for every instruction. It also provides
// ready/valid memory stalls, a post-reset wait, an optional multi-cycle
// muldiv execute, and a memory-timeout watchdog that lands in a sticky TRAP.
module mc_ctrl_fsm #(
  parameter int RESET_WAIT  = 1,
  parameter int EN_MULDIV   = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       is_muldiv,
  input  logic       mem_ready,
  input  logic       ex_done,
  output logic       branch,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       AdrSrc,
  output logic       mem_req,
  output logic       ex_start,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    S_WAIT     = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_MEMADR   = 5'd3,
    S_MEMREAD  = 5'd4,
    S_MEMWB    = 5'd5,
    S_MEMWRITE = 5'd6,
    S_EXECR    = 5'd7,
    S_EXECI    = 5'd8,
    S_ALUWB    = 5'd9,
    S_JAL      = 5'd10,
    S_BEQ      = 5'd11,
    S_BRT      = 5'd12,
    S_AUIPC    = 5'd13,
    S_LUI      = 5'd14,
    S_MULDIV   = 5'd15,
    S_TRAP     = 5'd31
  } state_t;

  // A zero-length post-reset wait means reset lands straight in FETCH.
  localparam state_t RST_STATE = (RESET_WAIT == 0) ? S_FETCH : S_WAIT;

  localparam int WW = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((RESET_WAIT > 0) ? RESET_WAIT - 1 : 0);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            in_md_q, in_md_d;   // was in MULDIV last cycle
  logic            to_fire;

  // Memory is requested only in the three access states.
  assign mem_req = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE);
  // Last stalled cycle allowed; the watchdog takes over on the next edge.
  assign to_fire    = mem_req && !mem_ready && (to_cnt_q == TO_LAST);
  assign trap_cause = cause_q;
  assign state_dbg  = state_q;

  // Datapath controls decoded from the current state.
  always_comb begin
    branch    = 1'b0;
    PCUpdate  = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    AdrSrc    = 1'b0;
    ex_start  = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin RegWrite = 1'b1; ResultSrc = 2'b01; end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        // Never issue a write on the cycle that hands off to the trap.
        MemWrite = !to_fire;
      end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      S_MULDIV: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b11;
        ex_start = !in_md_q;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL:      begin PCUpdate = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
      S_BEQ, S_BRT: begin branch = 1'b1; ALUSrcA = 2'b10; ALUOp = 2'b01; end
      S_AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_LUI:      begin RegWrite = 1'b1; ResultSrc = 2'b11; end
      S_TRAP:     trap = 1'b1;
      default: ;
    endcase
  end

  // Next-state, wait/timeout counters and trap cause.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cause_d    = cause_q;
    in_md_d    = (state_q == S_MULDIV);
    to_cnt_d   = (mem_req && !mem_ready) ? to_cnt_q + TW'(1) : '0;
    case (state_q)
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_FETCH;
        else wait_cnt_d = wait_cnt_q + WW'(1);
      end
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0110011: begin
            if (!is_muldiv) state_d = S_EXECR;
            else if (EN_MULDIV != 0) state_d = S_MULDIV;
            else begin state_d = S_TRAP; cause_d = 2'b01; end
          end
          7'b0010011: state_d = S_EXECI;
          7'b0000011, 7'b0100011, 7'b1100111: state_d = S_MEMADR;
          7'b1100011: state_d = S_BEQ;
          7'b1101111: state_d = S_JAL;
          7'b0010111: state_d = S_AUIPC;
          7'b0110111: state_d = S_LUI;
          default: begin state_d = S_TRAP; cause_d = 2'b01; end
        endcase
      end
      S_MEMADR: begin
        if (!op[5]) state_d = S_MEMREAD;
        else if (op == 7'b0100011) state_d = S_MEMWRITE;
        else state_d = S_JAL;
      end
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: state_d = S_ALUWB;
      S_MULDIV:   if (ex_done) state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_BRT;
      S_BRT:      state_d = S_FETCH;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default: begin state_d = S_TRAP; cause_d = 2'b01; end
    endcase
    if (to_fire) begin
      state_d = S_TRAP;
      cause_d = 2'b10;
    end
  end

  // State register; reset is asynchronous so controls drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      cause_q    <= 2'b00;
      in_md_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      cause_q    <= cause_d;
      in_md_q    <= in_md_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm. Two configurations share the stimulus:
// A = short wait, muldiv on, 8-cycle timeout; B = no wait, muldiv off, 255.
// A per-cycle reference model predicts every output of both instances.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = 7'b0110111;
  logic is_muldiv = 1'b0, mem_ready = 1'b0, ex_done = 1'b0;

  logic       br_a, pc_a, rw_a, mw_a, ir_a, adr_a, mr_a, xs_a, tr_a;
  logic [1:0] rs_a, sa_a, sb_a, ao_a, tc_a;
  logic [4:0] sd_a;
  logic       br_b, pc_b, rw_b, mw_b, ir_b, adr_b, mr_b, xs_b, tr_b;
  logic [1:0] rs_b, sa_b, sb_b, ao_b, tc_b;
  logic [4:0] sd_b;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.RESET_WAIT(3), .EN_MULDIV(1), .MEM_TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst), .op(op), .is_muldiv(is_muldiv), .mem_ready(mem_ready),
    .ex_done(ex_done), .branch(br_a), .PCUpdate(pc_a), .RegWrite(rw_a),
    .MemWrite(mw_a), .IRWrite(ir_a), .ResultSrc(rs_a), .ALUSrcA(sa_a),
    .ALUSrcB(sb_a), .ALUOp(ao_a), .AdrSrc(adr_a), .mem_req(mr_a),
    .ex_start(xs_a), .trap(tr_a), .trap_cause(tc_a), .state_dbg(sd_a));

  mc_ctrl_fsm #(.RESET_WAIT(0), .EN_MULDIV(0), .MEM_TIMEOUT(255)) u_b (
    .clk(clk), .rst(rst), .op(op), .is_muldiv(is_muldiv), .mem_ready(mem_ready),
    .ex_done(ex_done), .branch(br_b), .PCUpdate(pc_b), .RegWrite(rw_b),
    .MemWrite(mw_b), .IRWrite(ir_b), .ResultSrc(rs_b), .ALUSrcA(sa_b),
    .ALUSrcB(sb_b), .ALUOp(ao_b), .AdrSrc(adr_b), .mem_req(mr_b),
    .ex_start(xs_b), .trap(tr_b), .trap_cause(tc_b), .state_dbg(sd_b));

  wire [23:0] obs_a = {br_a, pc_a, rw_a, mw_a, ir_a, rs_a, sa_a, sb_a, ao_a,
                       adr_a, mr_a, xs_a, tr_a, tc_a, sd_a};
  wire [23:0] obs_b = {br_b, pc_b, rw_b, mw_b, ir_b, rs_b, sa_b, sb_b, ao_b,
                       adr_b, mr_b, xs_b, tr_b, tc_b, sd_b};

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h (state %0d) expected %h (state %0d)",
               tag, $time, obs, obs[4:0], exp, exp[4:0]);
    end
  endtask

  // Reference model: state numbers are the documented state_dbg values.
  int P_WAIT[2] = '{3, 0};
  int P_EN[2]   = '{1, 0};
  int P_TO[2]   = '{8, 255};
  int m_st[2], m_wc[2], m_tc[2], m_cause[2], m_mdc[2];

  function automatic void m_reset(int i);
    m_st[i] = (P_WAIT[i] == 0) ? 1 : 0;
    m_wc[i] = 0; m_tc[i] = 0; m_cause[i] = 0; m_mdc[i] = 0;
  endfunction

  function automatic bit m_memreq(int i);
    return m_st[i] == 1 || m_st[i] == 4 || m_st[i] == 6;
  endfunction

  function automatic bit m_fire(int i);
    return m_memreq(i) && !mem_ready && (m_tc[i] == P_TO[i] - 1);
  endfunction

  function automatic logic [23:0] m_out(int i);
    int rs = 0, a = 0, b = 0, aop = 0;
    bit br = 0, pc = 0, rw = 0, mw = 0, ir = 0, adr = 0, xs = 0, tr = 0;
    case (m_st[i])
      1:  begin b = 2; rs = 2; ir = mem_ready; pc = mem_ready; end
      2:  begin a = 1; b = 1; end
      3:  begin a = 2; b = 1; end
      4:  adr = 1;
      5:  begin rw = 1; rs = 1; end
      6:  begin adr = 1; mw = !m_fire(i); end
      7:  begin a = 2; aop = 2; end
      8:  begin a = 2; b = 1; aop = 2; end
      9:  rw = 1;
      10: begin pc = 1; a = 1; b = 2; end
      11, 12: begin br = 1; a = 2; aop = 1; end
      13: begin a = 1; b = 1; end
      14: begin rw = 1; rs = 3; end
      15: begin a = 2; aop = 3; xs = (m_mdc[i] == 0); end
      31: tr = 1;
      default: ;
    endcase
    return {br, pc, rw, mw, ir, 2'(rs), 2'(a), 2'(b), 2'(aop), adr,
            m_memreq(i), xs, tr, 2'(m_cause[i]), 5'(m_st[i])};
  endfunction

  function automatic void m_step(int i);
    int st = m_st[i];
    int ns = st;
    bit fire = m_fire(i);
    case (st)
      0:  if (m_wc[i] == P_WAIT[i] - 1) ns = 1; else m_wc[i]++;
      1:  if (mem_ready) ns = 2;
      2: begin
        case (op)
          7'b0110011: ns = !is_muldiv ? 7 : (P_EN[i] != 0 ? 15 : 31);
          7'b0010011: ns = 8;
          7'b0000011, 7'b0100011, 7'b1100111: ns = 3;
          7'b1100011: ns = 11;
          7'b1101111: ns = 10;
          7'b0010111: ns = 13;
          7'b0110111: ns = 14;
          default: ns = 31;
        endcase
        if (ns == 31) m_cause[i] = 1;
      end
      3:  ns = (op == 7'b0000011) ? 4 : (op == 7'b0100011) ? 6 : 10;
      4:  if (mem_ready) ns = 5;
      5:  ns = 1;
      6:  if (mem_ready) ns = 1;
      7, 8, 10, 13: ns = 9;
      9:  ns = 1;
      11: ns = 12;
      12: ns = 1;
      14: ns = 1;
      15: if (ex_done) ns = 9;
      default: ns = 31;
    endcase
    m_tc[i]  = (m_memreq(i) && !mem_ready) ? m_tc[i] + 1 : 0;
    m_mdc[i] = (st == 15) ? m_mdc[i] + 1 : 0;
    if (fire) begin ns = 31; m_cause[i] = 2; end
    m_st[i] = ns;
  endfunction

  logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100111, 7'b1100011, 7'b1101111, 7'b0010111,
                          7'b0110111, 7'b1111111};
  int rdy_pcts[4] = '{0, 30, 70, 100};

  initial begin
    int rdy_pct, done_pct, ill_pct;
    m_reset(0); m_reset(1);
    for (int ep = 0; ep < 60; ep++) begin
      rdy_pct  = rdy_pcts[$urandom_range(0, 3)];
      if (ep < 4) rdy_pct = 100;
      done_pct = $urandom_range(15, 100);
      ill_pct  = (ep % 5 == 4) ? 40 : 3;
      for (int cyc = 0; cyc < 70; cyc++) begin
        @(negedge clk);
        rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
        mem_ready = ($urandom_range(0, 99) < rdy_pct);
        ex_done   = ($urandom_range(0, 99) < done_pct);
        // Instruction only changes outside DECODE/MEMADR, as a real IR would.
        if (!(m_st[0] inside {2, 3}) && !(m_st[1] inside {2, 3})) begin
          if ($urandom_range(0, 99) < ill_pct)
            op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'($urandom_range(0, 127));
          else
            op = ops[$urandom_range(0, 8)];
          is_muldiv = ($urandom_range(0, 1) == 1);
        end
        #1;
        if (rst) begin m_reset(0); m_reset(1); end
        check("cfgA", obs_a, m_out(0));
        check("cfgB", obs_b, m_out(1));
        if (!rst) begin m_step(0); m_step(1); end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Next-generation main control FSM for the multicycle RV32I core.
- Same datapath control encodings as the current main FSM.
- Adds ready/valid memory handshake stalls, a configurable post-reset wait, optional multi-cycle M-extension execute, and a memory-timeout watchdog.
- Error handling is a clean trap state with cause code, replacing X outputs.
- Sits between the instruction register/opcode decode and the multicycle datapath, alongside the ALU decoder.

Parameters:
- RESET_WAIT, 1, cycles spent in WAIT after reset release before first fetch (0 = go straight to FETCH).
- EN_MULDIV, 1, 1 = R-type with is_muldiv=1 dispatches to MULDIV; 0 = such instructions trap as illegal.
- MEM_TIMEOUT, 255, maximum consecutive cycles mem_req may stay high without mem_ready before a bus-timeout trap (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op  in  7  instruction opcode [6:0]
- is_muldiv  in  1  instr funct7==7'b0000001 (meaningful only for op 0110011)
- mem_ready  in  1  memory accepted/completed the current access
- ex_done  in  1  multi-cycle muldiv unit result valid
- branch, PCUpdate, RegWrite, MemWrite, IRWrite  out  1 each  datapath controls
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each  datapath selects
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- mem_req  out  1  memory access request
- ex_start  out  1  single-cycle start pulse to muldiv unit
- trap  out  1  core halted in TRAP
- trap_cause  out  2  01 = illegal opcode, 10 = bus timeout, 00 = none
- state_dbg  out  5  current state encoding

Behaviour:
- Outputs are combinational from state, plus mem_ready/ex_done where stated. Unlisted outputs are 0.
- Reset: state=WAIT, wait counter=0, timeout counter=0, trap=0, trap_cause=00. All controls are 0 while in WAIT.
- WAIT: counts RESET_WAIT cycles, then goes to FETCH. If RESET_WAIT=0, reset goes directly to FETCH.
- FETCH:
  - Outputs: mem_req=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite=1 and PCUpdate=1 only in the cycle mem_ready=1.
  - Next state: DECODE on mem_ready, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01. Dispatch on op:
  - 0110011 → EXECR, or MULDIV if is_muldiv and EN_MULDIV; if is_muldiv and !EN_MULDIV → TRAP(01).
  - 0010011 → EXECI; 0000011/0100011/1100111 → MEMADR; 1100011 → BEQ; 1101111 → JAL; 0010111 → AUIPC; 0110111 → LUI.
  - Any other op → TRAP(01).
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next: MEMREAD if op[5]=0; MEMWRITE if op=0100011; JAL if op=1100111.
- MEMREAD: mem_req=1, AdrSrc=1. Next: MEMWB on mem_ready, else stay.
- MEMWB: RegWrite=1, ResultSrc=01. Next: FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, held until mem_ready. Next: FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- MULDIV:
  - Outputs: ALUSrcA=10, ALUOp=11.
  - ex_start=1 in the first MULDIV cycle only (entry flag).
  - Next: ALUWB in the cycle ex_done=1; ex_done in the same cycle as ex_start is legal.
- ALUWB: RegWrite=1. Next: FETCH.
- JAL: PCUpdate=1, ALUSrcA=01, ALUSrcB=10. Next: ALUWB.
- BEQ: branch=1, ALUSrcA=10, ALUOp=01. Next: BRT.
- BRT: same outputs as BEQ (target settle). Next: FETCH.
- AUIPC: ALUSrcA=01, ALUSrcB=01. Next: ALUWB.
- LUI: RegWrite=1, ResultSrc=11. Next: FETCH.
- Timeout counter:
  - Increments each cycle mem_req=1 && mem_ready=0.
  - Clears on mem_ready or when mem_req=0.
  - Reaching MEM_TIMEOUT → TRAP(10) next cycle; no IRWrite/MemWrite is issued in that transition.
- TRAP: all controls 0, trap=1, trap_cause held. Sticky until rst.
- rst asserted mid-operation (e.g. during MEMWRITE with MemWrite=1) drops all controls to 0 immediately (async) and returns to WAIT.
- state_dbg encoding: WAIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, JAL=10, BEQ=11, BRT=12, AUIPC=13, LUI=14, MULDIV=15, TRAP=31.

Test Plan:
- Reset, RESET_WAIT=3, mem_ready=1 → state_dbg 0,0,0, then 1; IRWrite=PCUpdate=1 in the first FETCH cycle only.
- lw (op 0000011), mem_ready low 2 cycles in MEMREAD → sequence 1,2,3,4,4,4,5,1; RegWrite=1 with ResultSrc=01 exactly once.
- sw (op 0100011), mem_ready delayed 4 cycles → MemWrite held 5 cycles, then FETCH; RegWrite never 1.
- mul (op 0110011, is_muldiv=1), ex_done after 6 cycles → ex_start pulses 1 cycle, ALUOp=11 throughout, ALUWB RegWrite=1; repeat with EN_MULDIV=0 → trap=1, trap_cause=01.
- op=7'b1111111 → TRAP, trap_cause=01, all controls 0 for 20 cycles; then rst → WAIT.
- MEM_TIMEOUT=8, mem_ready stuck 0 in FETCH → trap asserted on cycle 9, cause=10, IRWrite never 1.
